// File: rtl/restoring_divider_pkg.sv
// Shared types and defaults for the restoring divider.
// Holds the controller state encoding and the default operand width.
package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/restoring_divider_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bi, with borrow out Bo.
// Cells chain borrow-out to borrow-in to form the trial subtractor.
module full_subtractor (
  output logic D,
  output logic Bo,
  input  logic A,
  input  logic B,
  input  logic Bi
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider (DIV/DIVU) producing one quotient bit per cycle.
// Signed operations divide magnitudes, then fix up the signs in a final cycle.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             dividend_neg, divisor_neg;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

  assign dividend_neg = signed_op & dividend[WIDTH-1];
  assign divisor_neg  = signed_op & divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

  // Trial subtraction: ({rem,quo} << 1) upper part minus divisor magnitude.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   subtrahend;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] borrow;
  logic             trial_nonneg;
  logic             trial_msb_unused;

  assign shifted    = {rem_q, quo_q[WIDTH-1]};
  assign subtrahend = {1'b0, dvs_q};
  assign borrow[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
      full_subtractor u_fs (
        .D  (trial[gi]),
        .Bo (borrow[gi+1]),
        .A  (shifted[gi]),
        .B  (subtrahend[gi]),
        .Bi (borrow[gi])
      );
    end
  endgenerate

  // Both operands are non-negative, so the final borrow alone gives the sign.
  assign trial_nonneg     = ~borrow[WIDTH+1];
  assign trial_msb_unused = trial[WIDTH];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d   = RUN;
            rem_d     = '0;
            quo_d     = dividend_mag;
            dvs_d     = divisor_mag;
            neg_quo_d = dividend_neg ^ divisor_neg;
            neg_rem_d = dividend_neg;
            cnt_d     = CNT_LOAD;
            dbz_d     = 1'b0;
          end
        end
      end

      RUN: begin
        rem_d = trial_nonneg ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_nonneg};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d     = DONE;
        done_d      = 1'b1;
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
